// File: rtl/rmii_tx_framer.sv
// rmii_tx_framer: byte stream to RMII TX dibits with preamble, SFD, FCS and IPG.
// Define RMII_TX_PAD_EN to zero-pad short frames to MIN_LEN before the FCS.
module rmii_tx_framer #(
  parameter int IPG_BYTES = 12,
  parameter int MIN_LEN   = 60,
  parameter int SLOW_DIV  = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rmii_clk,
  input  logic       fast_eth,
  input  logic [7:0] s_data,
  input  logic       s_valid,
  input  logic       s_last,
  output logic       s_ready,
  output logic       rm_tx_en,
  output logic [1:0] rm_tx_data,
  output logic       busy,
  output logic       frame_done,
  output logic       underrun
);

  typedef enum logic [2:0] {
    IDLE, PRE, SFD, DATA, FCS, IPG
`ifdef RMII_TX_PAD_EN
    , PAD
`endif
  } state_t;

  localparam logic [7:0]  IPG_LAST = 8'(IPG_BYTES - 1);
  localparam logic [7:0]  DIV_MAX  = 8'(SLOW_DIV - 1);
  localparam logic [10:0] LEN_MAX  = 11'h7FF;
`ifdef RMII_TX_PAD_EN
  localparam logic [10:0] MIN_L    = 11'(MIN_LEN);
`endif

  state_t      state, state_n;
  logic [1:0]  di, di_n;
  logic [7:0]  idx, idx_n;
  logic [10:0] len, len_n;
  logic [5:0]  sh, sh_n;
  logic [31:0] crc, crc_n;
  logic        last_q, last_n;
  logic        fast_q, fast_n;
  logic [7:0]  div, div_n;
  logic        fcs_tail, fcs_tail_n;
  logic        tx_en_n;
  logic [1:0]  tx_data_n;
  logic        frame_done_n, underrun_n;
  logic [7:0]  hold;
  logic        hold_last, hold_full;
  logic        consume, accept, slot;
  logic [7:0]  cur;
  logic [1:0]  dib;
  logic [31:0] xcrc;

  function automatic logic [31:0] crc2(
    input logic [31:0] c,
    input logic [1:0]  d
  );
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 2; i++)
      r = (r >> 1) ^ ((r[0] ^ d[i]) ? 32'hEDB88320 : 32'h0);
    return r;
  endfunction

  assign s_ready = ~hold_full;
  assign accept  = s_valid & ~hold_full;
  assign busy    = (state != IDLE) | hold_full;
  assign slot    = rmii_clk & (fast_q | (div == DIV_MAX));
  assign xcrc    = ~crc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold      <= '0;
      hold_last <= 1'b0;
      hold_full <= 1'b0;
    end else if (consume) begin
      hold_full <= 1'b0;
    end else if (accept) begin
      hold      <= s_data;
      hold_last <= s_last;
      hold_full <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      di         <= '0;
      idx        <= '0;
      len        <= '0;
      sh         <= '0;
      crc        <= '1;
      last_q     <= 1'b0;
      fast_q     <= 1'b1;
      div        <= '0;
      fcs_tail   <= 1'b0;
      rm_tx_en   <= 1'b0;
      rm_tx_data <= '0;
      frame_done <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      state      <= state_n;
      di         <= di_n;
      idx        <= idx_n;
      len        <= len_n;
      sh         <= sh_n;
      crc        <= crc_n;
      last_q     <= last_n;
      fast_q     <= fast_n;
      div        <= div_n;
      fcs_tail   <= fcs_tail_n;
      rm_tx_en   <= tx_en_n;
      rm_tx_data <= tx_data_n;
      frame_done <= frame_done_n;
      underrun   <= underrun_n;
    end
  end

  always_comb begin
    state_n      = state;
    di_n         = di;
    idx_n        = idx;
    len_n        = len;
    sh_n         = sh;
    crc_n        = crc;
    last_n       = last_q;
    fast_n       = fast_q;
    div_n        = div;
    fcs_tail_n   = fcs_tail;
    tx_en_n      = rm_tx_en;
    tx_data_n    = rm_tx_data;
    frame_done_n = 1'b0;
    underrun_n   = 1'b0;
    consume      = 1'b0;
    cur          = 8'h00;

    unique case (state)
      PRE:     cur = 8'h55;
      SFD:     cur = 8'hD5;
      DATA:    cur = hold;
      FCS: begin
        unique case (idx[1:0])
          2'd0:    cur = xcrc[7:0];
          2'd1:    cur = xcrc[15:8];
          2'd2:    cur = xcrc[23:16];
          default: cur = xcrc[31:24];
        endcase
      end
      default: cur = 8'h00;
    endcase
    dib = (di == 2'd0) ? cur[1:0] : sh[1:0];

    if (state != IDLE && rmii_clk)
      div_n = (div == DIV_MAX) ? '0 : div + 8'd1;

    if (state == IDLE) begin
      if (hold_full) begin
        state_n = PRE;
        fast_n  = fast_eth;
        di_n    = '0;
        idx_n   = '0;
        div_n   = '0;
      end
    end else if (slot) begin
      di_n      = di + 2'd1;
      tx_en_n   = (state != IPG);
      tx_data_n = (state == IPG) ? 2'b00 : dib;
      sh_n      = (di == 2'd0) ? cur[7:2] : {2'b00, sh[5:2]};
      if (state == IPG && fcs_tail) begin
        frame_done_n = 1'b1;
        fcs_tail_n   = 1'b0;
      end
      unique case (state)
        PRE: begin
          if (di == 2'd3) begin
            if (idx == 8'd6) begin
              state_n = SFD;
              idx_n   = '0;
            end else begin
              idx_n = idx + 8'd1;
            end
          end
        end
        SFD: begin
          if (di == 2'd3) begin
            state_n = DATA;
            crc_n   = '1;
            len_n   = '0;
          end
        end
        DATA: begin
          // No byte ready at the boundary: abort and drop tx_en now.
          if (di == 2'd0 && !hold_full) begin
            underrun_n = 1'b1;
            tx_en_n    = 1'b0;
            tx_data_n  = 2'b00;
            state_n    = IPG;
            di_n       = '0;
            idx_n      = '0;
          end else begin
            crc_n = crc2(crc, dib);
            if (di == 2'd0) begin
              consume = 1'b1;
              last_n  = hold_last;
              if (len != LEN_MAX) len_n = len + 11'd1;
            end
            if (di == 2'd3 && last_q) begin
              state_n = FCS;
              idx_n   = '0;
`ifdef RMII_TX_PAD_EN
              if (len < MIN_L) state_n = PAD;
`endif
            end
          end
        end
`ifdef RMII_TX_PAD_EN
        PAD: begin
          crc_n = crc2(crc, dib);
          if (di == 2'd0 && len != LEN_MAX) len_n = len + 11'd1;
          if (di == 2'd3 && len >= MIN_L) begin
            state_n = FCS;
            idx_n   = '0;
          end
        end
`endif
        FCS: begin
          if (di == 2'd3) begin
            if (idx == 8'd3) begin
              state_n    = IPG;
              idx_n      = '0;
              fcs_tail_n = 1'b1;
            end else begin
              idx_n = idx + 8'd1;
            end
          end
        end
        IPG: begin
          if (di == 2'd3) begin
            if (idx == IPG_LAST) state_n = IDLE;
            else idx_n = idx + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rmii_tx_framer.sv
// tb_rmii_tx_framer: random frames through rmii_tx_framer, checked
// against a byte-level Ethernet frame model with a bitwise CRC-32.
module tb_rmii_tx_framer;

  typedef logic [7:0] bq_t[$];

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rmii_clk = 1'b0;
  logic       fast_eth = 1'b1;
  logic [7:0] s_data = 8'h00;
  logic       s_valid = 1'b0;
  logic       s_last = 1'b0;
  logic       s_ready, rm_tx_en, busy, frame_done, underrun;
  logic [1:0] rm_tx_data;

  int n_cmp = 0;
  int n_bad = 0;

  logic [3:0] smp[$];
  int   fd_cnt = 0;
  int   ur_cnt = 0;
  int   ur_idx = -1;
  logic ur_en = 1'b1;

  bq_t rx, exp_q;
  int  rx_start, rx_end, rx_slots, hold_err, pos;

  rmii_tx_framer dut (
    .clk        (clk),
    .rst        (rst),
    .rmii_clk   (rmii_clk),
    .fast_eth   (fast_eth),
    .s_data     (s_data),
    .s_valid    (s_valid),
    .s_last     (s_last),
    .s_ready    (s_ready),
    .rm_tx_en   (rm_tx_en),
    .rm_tx_data (rm_tx_data),
    .busy       (busy),
    .frame_done (frame_done),
    .underrun   (underrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) rmii_clk <= ~rmii_clk;

  // One sample per RMII cycle, taken mid-cycle after the update edge.
  always @(negedge clk) begin
    if (frame_done) fd_cnt++;
    if (underrun) ur_cnt++;
    if (!rmii_clk) begin
      if (underrun) begin
        ur_idx = smp.size();
        ur_en  = rm_tx_en;
      end
      smp.push_back({busy, rm_tx_en, rm_tx_data});
    end
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  function automatic logic [31:0] crc_byte(input logic [31:0] c,
                                           input logic [7:0] b);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++)
      r = (r >> 1) ^ ((r[0] ^ b[i]) ? 32'hEDB88320 : 32'h0);
    return r;
  endfunction

  task automatic build_exp(input bq_t d);
    bq_t body;
    logic [31:0] c;
    body = d;
`ifdef RMII_TX_PAD_EN
    while (body.size() < 60) body.push_back(8'h00);
`endif
    exp_q.delete();
    for (int i = 0; i < 7; i++) exp_q.push_back(8'h55);
    exp_q.push_back(8'hD5);
    c = 32'hFFFFFFFF;
    foreach (body[i]) begin
      exp_q.push_back(body[i]);
      c = crc_byte(c, body[i]);
    end
    c = ~c;
    for (int i = 0; i < 4; i++) exp_q.push_back(c[8*i +: 8]);
  endtask

  task automatic decode(input int div);
    int i, k;
    logic [7:0] b;
    rx.delete();
    hold_err = 0;
    i = pos;
    while (i < smp.size() && !smp[i][2]) i++;
    rx_start = i;
    k = 0;
    b = 8'h00;
    while (i < smp.size() && smp[i][2]) begin
      for (int j = 1; j < div; j++)
        if (i + j >= smp.size() || smp[i+j][2:0] != smp[i][2:0])
          hold_err++;
      b = {smp[i][1:0], b[7:2]};
      k++;
      if (k % 4 == 0) rx.push_back(b);
      i += div;
    end
    rx_slots = k;
    rx_end   = i;
    pos      = i;
  endtask

  task automatic check_frame(input bq_t d, input int div);
    int bad;
    logic [31:0] c;
    decode(div);
    build_exp(d);
    chk("nbytes", rx.size(), exp_q.size());
    bad = 0;
    foreach (exp_q[i])
      if (i >= rx.size() || rx[i] !== exp_q[i]) bad++;
    chk("bytes", bad, 0);
    chk("slots", rx_slots, exp_q.size() * 4);
    c = 32'hFFFFFFFF;
    for (int i = 8; i < rx.size(); i++) c = crc_byte(c, rx[i]);
    chk("residue", c, 32'hDEBB20E3);
    if (div > 1) chk("hold", hold_err, 0);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic l);
    int t;
    t = 0;
    s_data  = b;
    s_last  = l;
    s_valid = 1'b1;
    while (!s_ready && t < 20000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 20000) chk("send_timeout", 0, 1);
    @(negedge clk);
  endtask

  task automatic send_frame(input bq_t d, input int n, input bit keep);
    for (int i = 0; i < n; i++) send_byte(d[i], i == d.size() - 1);
    if (!keep) begin
      s_valid = 1'b0;
      s_last  = 1'b0;
    end
  endtask

  task automatic wait_idle(input int lim);
    int t;
    t = 0;
    repeat (3) @(negedge clk);
    while (busy !== 1'b0 && t < lim) begin
      @(negedge clk);
      t++;
    end
    chk("idle_timeout", t < lim, 1);
    repeat (4) @(negedge clk);
  endtask

  function automatic bq_t rnd_frame(input int n);
    bq_t q;
    for (int i = 0; i < n; i++) q.push_back(8'($urandom));
    return q;
  endfunction

  task automatic clear_cap();
    smp.delete();
    pos = 0;
  endtask

  initial begin
    bq_t d, d2;
    int f0, u0, e1, nb, n;

    repeat (3) @(negedge clk);
    chk("rst_en", rm_tx_en, 0);
    chk("rst_data", rm_tx_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", s_ready, 1);
    chk("rst_done", frame_done, 0);
    chk("rst_ur", underrun, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // "123456789" at 100 Mbit
    clear_cap();
    f0 = fd_cnt;
    d.delete();
    for (int i = 0; i < 9; i++) d.push_back(8'h31 + 8'(i));
    send_frame(d, d.size(), 0);
    wait_idle(5000);
    check_frame(d, 1);
    chk("t1_done", fd_cnt - f0, 1);
`ifndef RMII_TX_PAD_EN
    chk("t1_slots", rx_slots, 84);
    chk("t1_fcs", {rx[20], rx[19], rx[18], rx[17]}, 32'hCBF43926);
`endif

    // 14-byte frame
    clear_cap();
    d = rnd_frame(14);
    send_frame(d, d.size(), 0);
    wait_idle(5000);
    check_frame(d, 1);
`ifdef RMII_TX_PAD_EN
    chk("t2_len", rx.size() - 8, 64);
`endif

    // back-to-back with s_valid held
    clear_cap();
    d  = rnd_frame(10);
    d2 = rnd_frame(12);
    send_frame(d, d.size(), 1);
    send_frame(d2, d2.size(), 0);
    wait_idle(8000);
    check_frame(d, 1);
    e1 = rx_end;
    check_frame(d2, 1);
    chk("ipg_gap", rx_start - e1, 48);
    nb = 0;
    for (int i = e1; i < rx_start; i++) if (!smp[i][3]) nb++;
    chk("ipg_busy", nb, 0);

    // underrun after 20 of 64 bytes
    clear_cap();
    ur_idx = -1;
    f0 = fd_cnt;
    u0 = ur_cnt;
    d = rnd_frame(64);
    send_frame(d, 20, 0);
    wait_idle(5000);
    decode(1);
    build_exp(d);
    chk("ur_pulse", ur_cnt - u0, 1);
    chk("ur_no_done", fd_cnt - f0, 0);
    chk("ur_nbytes", rx.size(), 28);
    nb = 0;
    for (int i = 0; i < 28; i++) if (rx[i] !== exp_q[i]) nb++;
    chk("ur_bytes", nb, 0);
    chk("ur_en_low", ur_en, 0);
    chk("ur_slot", ur_idx, rx_end);
    d = rnd_frame(25);
    send_frame(d, d.size(), 0);
    wait_idle(5000);
    check_frame(d, 1);

    // 10 Mbit, fast_eth toggled mid-frame
    clear_cap();
    fast_eth = 1'b0;
    repeat (2) @(negedge clk);
    d.delete();
    for (int i = 0; i < 9; i++) d.push_back(8'h31 + 8'(i));
    fork
      send_frame(d, d.size(), 0);
      begin
        repeat (600) @(negedge clk);
        fast_eth = 1'b1;
      end
    join
    wait_idle(20000);
    check_frame(d, 10);
`ifndef RMII_TX_PAD_EN
    chk("slow_fcs", {rx[20], rx[19], rx[18], rx[17]}, 32'hCBF43926);
`endif

    // async reset mid-DATA
    clear_cap();
    u0 = ur_cnt;
    d = rnd_frame(40);
    send_frame(d, 15, 0);
    chk("pre_rst_en", rm_tx_en, 1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_en", rm_tx_en, 0);
    chk("mid_rst_data", rm_tx_data, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ready", s_ready, 1);
    chk("mid_rst_ur", ur_cnt - u0, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    clear_cap();
    d = rnd_frame(20);
    send_frame(d, d.size(), 0);
    wait_idle(5000);
    check_frame(d, 1);

    // random frames, mixed rates
    for (int k = 0; k < 5; k++) begin
      clear_cap();
      n = $urandom_range(1, 70);
      fast_eth = (n > 16) ? 1'b1 : 1'($urandom);
      repeat (2) @(negedge clk);
      d = rnd_frame(n);
      send_frame(d, d.size(), 0);
      wait_idle(30000);
      check_frame(d, fast_eth ? 1 : 10);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rmii_tx_framer.md
Name: rmii_tx_framer

Overview:
- Ethernet MAC transmit framer between the UDP frame builder (byte source) and the RMII pins.
- Accepts a raw frame byte stream (destination MAC through last payload byte) over a valid/ready/last handshake.
- Emits preamble, SFD, the data, zero pad to minimum length, IEEE 802.3 FCS and the inter-frame gap as RMII dibits.
- Runs on the 100 MHz system clock, using the registered clk/2 RMII clock as a slot enable.

Parameters:
- IPG_BYTES, 12, inter-frame gap length in byte times (tx_en low).
- MIN_LEN, 60, minimum frame length before FCS; used only when padding is compiled in.
- SLOW_DIV, 10, RMII clock cycles per dibit in 10 Mbit mode.

Ports:
- clk  in  1  system clock, 100 MHz.
- rst  in  1  asynchronous, active-high reset.
- rmii_clk  in  1  registered 50 MHz RMII clock, toggling every clk.
- fast_eth  in  1  1 = 100 Mbit, 0 = 10 Mbit; sampled only in IDLE.
- s_data  in  8  frame byte.
- s_valid  in  1  s_data is valid.
- s_last  in  1  marks the final data byte of the frame.
- s_ready  out  1  holding register empty; a byte is accepted when s_valid && s_ready.
- rm_tx_en  out  1  RMII TX_EN.
- rm_tx_data  out  2  RMII TXD[1:0].
- busy  out  1  high from the first accepted byte until the IPG ends.
- frame_done  out  1  one-clk pulse when the last FCS dibit slot ends.
- underrun  out  1  one-clk pulse when a frame is aborted.

Behaviour:
- Reset values: rm_tx_en=0, rm_tx_data=0, busy=0, frame_done=0, underrun=0, s_ready=1. Async reset mid-frame drops rm_tx_en at once; the partial frame is discarded.
- Slot strobe: a clk edge with rmii_clk==1 (RMII falling edge). Outputs update only on slot strobes, so they are stable at the next RMII rising edge. In 10 Mbit mode only every SLOW_DIV-th strobe is a slot.
- Dibit order: bits[1:0] first, then [3:2], [5:4], [7:6]. One byte = 4 slots.
- Holding register: 1 byte plus its last flag. s_ready = ~hold_full. Loading into the shift register at a byte boundary frees the holding register on the same clk.
- States:
  - IDLE: rm_tx_en=0. When hold_full, go to PRE, latch fast_eth, set busy=1.
  - PRE: 7 bytes of 0x55.
  - SFD: 0xD5. At the byte end, init CRC to 0xFFFFFFFF.
  - DATA: shift out bytes from the holding register. If the holding register is empty at a byte boundary: underrun pulse, rm_tx_en=0 on that slot, go to IPG.
  - After a byte with last=1: go to PAD if the byte count < MIN_LEN, else FCS.
  - PAD: transmit 0x00 until the count equals MIN_LEN.
  - FCS: 4 bytes of ~crc, LSB byte first. frame_done pulses at the end.
  - IPG: IPG_BYTES*4 slots with tx_en=0, then IDLE with busy=0. The holding register may refill during IPG, but the next frame starts only from IDLE.
- CRC: reflected polynomial 0xEDB88320, processed 2 bits per slot, LSB first, over DATA and PAD bytes only.
- Byte counter: 11 bits, saturating at 2047. No maximum-length check.
- s_valid while the holding register is full: ignored, since s_ready=0.
- rm_tx_en timing: goes high on the first preamble slot and falls on the slot after the last FCS dibit.
- Frame duration at 100 Mbit: (8+L+4)*4 slots = (8+L+4)*8 clk cycles, where L is the padded length.

Optional Feature:
- RMII_TX_PAD_EN defined: frames shorter than MIN_LEN are zero-padded to MIN_LEN, and the FCS covers the pad.
- RMII_TX_PAD_EN undefined: no PAD state. The FCS follows the last data byte directly and MIN_LEN is unused.

Test Plan:
- Pad off, 100 Mbit, bytes "123456789" (0x31..0x39):
  - Required: 0x55 x7, 0xD5, the 9 bytes, then FCS 0x26 0x39 0xF4 0xCB.
  - rm_tx_en high for exactly 84 slots (168 clk); one frame_done pulse.
- Pad on, 100 Mbit, 14-byte frame:
  - Required: 46 bytes of 0x00 after the data, 64 bytes after SFD.
  - CRC run over data+pad+FCS gives residue 0xDEBB20E3.
- Back-to-back frames with s_valid held high: exactly 48 slots of rm_tx_en=0 between frames; busy stays high through the IPG.
- Underrun:
  - Stimulus: drop s_valid after byte 20 of a 64-byte frame.
  - Required: underrun pulse, rm_tx_en low within 1 slot, no FCS emitted, next frame transmitted correctly afterwards.
- 10 Mbit (fast_eth=0): each dibit held 10 RMII cycles; FCS identical to the first test. Toggling fast_eth mid-frame has no effect.
- Async rst asserted mid-DATA: outputs reach reset values immediately. After release, a new frame starts cleanly with the full 7-byte preamble.
